tx_frontend_corr: RTL and testbench

Transmit-side analog frontend correction between the DUC output and the DAC interface. It takes 24-bit I/Q baseband samples and applies IQ imbalance correction (magnitude and phase) and per-channel DC offset. It then rounds and saturates the result to the DAC width and optionally swaps the I/Q-to-DAC mapping. All correction values are programmed over the standard settings bus, and the block is a fixed-latency pipeline.

---
 rtl/tx_frontend_corr_if.sv | 24 ++
 rtl/tx_frontend_corr.sv | 175 +++++++++++++++++
 tb/tb_tx_frontend_corr.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frontend_corr_if.sv
// Settings bus, baseband sample input and DAC output bundle for tx_frontend_corr.
interface tx_frontend_corr_if #(
  parameter int unsigned WIDTH_OUT = 16
) ();
  logic                        set_stb;
  logic [7:0]                  set_addr;
  logic [31:0]                 set_data;
  logic signed [23:0]          i_in;
  logic signed [23:0]          q_in;
  logic                        run;
  logic signed [WIDTH_OUT-1:0] dac_a;
  logic signed [WIDTH_OUT-1:0] dac_b;
  logic                        clip;

  modport master (
    output set_stb, set_addr, set_data, i_in, q_in, run,
    input  dac_a, dac_b, clip
  );

  modport slave (
    input  set_stb, set_addr, set_data, i_in, q_in, run,
    output dac_a, dac_b, clip
  );
endinterface

// File: rtl/tx_frontend_corr.sv
// Transmit frontend correction: IQ imbalance and DC offset correction, rounding and
// saturation to DAC width, optional I/Q swap. Fixed 4-cycle pipeline.
module tx_frontend_corr #(
  parameter int unsigned BASE      = 0,
  parameter bit          IQCOMP_EN = 1'b1,
  parameter int unsigned WIDTH_OUT = 16
) (
  input logic               clk,
  input logic               rst,
  tx_frontend_corr_if.slave bus
);

  localparam logic [7:0] AddrDcI   = 8'(BASE);
  localparam logic [7:0] AddrDcQ   = 8'(BASE + 32'd1);
  localparam logic [7:0] AddrMag   = 8'(BASE + 32'd2);
  localparam logic [7:0] AddrPhase = 8'(BASE + 32'd3);
  localparam logic [7:0] AddrSwap  = 8'(BASE + 32'd4);

  localparam logic signed [23:0] SatMax = 24'sh7FFFFF;
  localparam logic signed [23:0] SatMin = 24'sh800000;

  // Settings registers
  logic signed [23:0] dc_i_q, dc_q_q;
  logic signed [17:0] mag_corr_q, phase_corr_q;
  logic               swap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_i_q       <= '0;
      dc_q_q       <= '0;
      mag_corr_q   <= '0;
      phase_corr_q <= '0;
      swap_q       <= 1'b0;
    end else if (bus.set_stb) begin
      case (bus.set_addr)
        AddrDcI:   dc_i_q       <= bus.set_data[23:0];
        AddrDcQ:   dc_q_q       <= bus.set_data[23:0];
        AddrMag:   mag_corr_q   <= bus.set_data[17:0];
        AddrPhase: phase_corr_q <= bus.set_data[17:0];
        AddrSwap:  swap_q       <= bus.set_data[0];
        default:   ;
      endcase
    end
  end

  // S1: input gating
  logic signed [23:0] i1_q, q1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q <= '0;
      q1_q <= '0;
    end else begin
      i1_q <= bus.run ? bus.i_in : '0;
      q1_q <= bus.run ? bus.q_in : '0;
    end
  end

  // S2: correction products, both taken from the I channel
  logic signed [17:0] i1_hi;
  logic signed [35:0] pi_d, pq_d, pi_q, pq_q;
  logic signed [23:0] i2_q, q2_q;

  assign i1_hi = i1_q[23:6];

  if (IQCOMP_EN) begin : g_mult
    assign pi_d = 36'(i1_hi) * 36'(mag_corr_q);
    assign pq_d = 36'(i1_hi) * 36'(phase_corr_q);
  end else begin : g_nomult
    logic unused_corr;
    assign pi_d        = '0;
    assign pq_d        = '0;
    assign unused_corr = ^{i1_hi, mag_corr_q, phase_corr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q <= '0;
      pq_q <= '0;
      i2_q <= '0;
      q2_q <= '0;
    end else begin
      pi_q <= pi_d;
      pq_q <= pq_d;
      i2_q <= i1_q;
      q2_q <= q1_q;
    end
  end

  // S3: add correction and DC offset at 26 bits, saturate back to 24
  logic signed [23:0] pi_hi, pq_hi;
  logic signed [25:0] sum_i, sum_q;
  logic               ovf3_i, ovf3_q;
  logic signed [23:0] s3_i_d, s3_q_d;
  logic signed [23:0] s3_i_q, s3_q_q;
  logic               sat3_i_q, sat3_q_q;

  assign pi_hi = pi_q[35:12];
  assign pq_hi = pq_q[35:12];
  assign sum_i = 26'(i2_q) + 26'(pi_hi) + 26'(dc_i_q);
  assign sum_q = 26'(q2_q) + 26'(pq_hi) + 26'(dc_q_q);

  // In range only when the top three bits are a pure sign extension
  assign ovf3_i = !(sum_i[25:23] == 3'b000 || sum_i[25:23] == 3'b111);
  assign ovf3_q = !(sum_q[25:23] == 3'b000 || sum_q[25:23] == 3'b111);
  assign s3_i_d = ovf3_i ? (sum_i[25] ? SatMin : SatMax) : sum_i[23:0];
  assign s3_q_d = ovf3_q ? (sum_q[25] ? SatMin : SatMax) : sum_q[23:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_i_q   <= '0;
      s3_q_q   <= '0;
      sat3_i_q <= 1'b0;
      sat3_q_q <= 1'b0;
    end else begin
      s3_i_q   <= s3_i_d;
      s3_q_q   <= s3_q_d;
      sat3_i_q <= ovf3_i;
      sat3_q_q <= ovf3_q;
    end
  end

  // S4: round half-up to DAC width, saturate, swap
  logic signed [WIDTH_OUT-1:0] out_i, out_q;
  logic                        ovf4_i, ovf4_q;

  if (WIDTH_OUT < 24) begin : g_round
    localparam int unsigned Shift = 24 - WIDTH_OUT;
    localparam logic signed [24:0] Half = 25'sd1 <<< (Shift - 1);
    localparam logic signed [WIDTH_OUT-1:0] OutMax = {1'b0, {(WIDTH_OUT - 1){1'b1}}};

    logic signed [24:0]   rnd_i, rnd_q;
    logic [WIDTH_OUT:0]   top_i, top_q;
    logic                 unused_rnd;

    assign rnd_i = 25'(s3_i_q) + Half;
    assign rnd_q = 25'(s3_q_q) + Half;
    assign top_i = rnd_i[24:Shift];
    assign top_q = rnd_q[24:Shift];
    // Only a positive carry into the sign bit is possible here
    assign ovf4_i = top_i[WIDTH_OUT] ^ top_i[WIDTH_OUT-1];
    assign ovf4_q = top_q[WIDTH_OUT] ^ top_q[WIDTH_OUT-1];
    assign out_i  = ovf4_i ? OutMax : top_i[WIDTH_OUT-1:0];
    assign out_q  = ovf4_q ? OutMax : top_q[WIDTH_OUT-1:0];
    assign unused_rnd = ^{rnd_i[Shift-1:0], rnd_q[Shift-1:0]};
  end else begin : g_noround
    assign out_i  = s3_i_q;
    assign out_q  = s3_q_q;
    assign ovf4_i = 1'b0;
    assign ovf4_q = 1'b0;
  end

  logic signed [WIDTH_OUT-1:0] dac_a_q, dac_b_q;
  logic                        clip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_a_q <= '0;
      dac_b_q <= '0;
      clip_q  <= 1'b0;
    end else begin
      dac_a_q <= swap_q ? out_q : out_i;
      dac_b_q <= swap_q ? out_i : out_q;
      clip_q  <= sat3_i_q | sat3_q_q | ovf4_i | ovf4_q;
    end
  end

  assign bus.dac_a = dac_a_q;
  assign bus.dac_b = dac_b_q;
  assign bus.clip  = clip_q;

  logic unused_bits;
  assign unused_bits = ^{bus.set_data[31:24], pi_q[11:0], pq_q[11:0]};

endmodule

// File: tb/tb_tx_frontend_corr.sv
// Self-checking bench for tx_frontend_corr: per-sample behavioural model checked every
// cycle on two instances (IQ correction on and off), plus literal expectations.
module tb_tx_frontend_corr;

  localparam int unsigned Base = 16;
  localparam int unsigned W    = 16;
  localparam int          N    = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_frontend_corr_if #(.WIDTH_OUT(W)) bus0 ();
  tx_frontend_corr_if #(.WIDTH_OUT(W)) bus1 ();

  assign bus1.set_stb  = bus0.set_stb;
  assign bus1.set_addr = bus0.set_addr;
  assign bus1.set_data = bus0.set_data;
  assign bus1.i_in     = bus0.i_in;
  assign bus1.q_in     = bus0.q_in;
  assign bus1.run      = bus0.run;

  tx_frontend_corr #(.BASE(Base), .IQCOMP_EN(1'b1), .WIDTH_OUT(W)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tx_frontend_corr #(.BASE(Base), .IQCOMP_EN(1'b0), .WIDTH_OUT(W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Per-edge history of what the design saw, and the settings in force at that edge
  bit                 rst_h  [N];
  bit                 run_h  [N];
  bit                 swap_h [N];
  logic signed [23:0] i_h    [N];
  logic signed [23:0] q_h    [N];
  logic signed [23:0] dci_h  [N];
  logic signed [23:0] dcq_h  [N];
  logic signed [17:0] mag_h  [N];
  logic signed [17:0] ph_h   [N];

  logic signed [23:0] m_dci  = '0;
  logic signed [23:0] m_dcq  = '0;
  logic signed [17:0] m_mag  = '0;
  logic signed [17:0] m_ph   = '0;
  bit                 m_swap = 1'b0;
  int                 edge_n = 0;

  always @(posedge clk) begin
    if (edge_n < N) begin
      rst_h[edge_n]  <= rst;
      run_h[edge_n]  <= bus0.run;
      i_h[edge_n]    <= bus0.i_in;
      q_h[edge_n]    <= bus0.q_in;
      dci_h[edge_n]  <= m_dci;
      dcq_h[edge_n]  <= m_dcq;
      mag_h[edge_n]  <= m_mag;
      ph_h[edge_n]   <= m_ph;
      swap_h[edge_n] <= m_swap;
    end
    edge_n <= edge_n + 1;
    if (rst) begin
      m_dci  <= '0;
      m_dcq  <= '0;
      m_mag  <= '0;
      m_ph   <= '0;
      m_swap <= 1'b0;
    end else if (bus0.set_stb) begin
      if (bus0.set_addr == 8'(Base))      m_dci  <= bus0.set_data[23:0];
      if (bus0.set_addr == 8'(Base + 1))  m_dcq  <= bus0.set_data[23:0];
      if (bus0.set_addr == 8'(Base + 2))  m_mag  <= bus0.set_data[17:0];
      if (bus0.set_addr == 8'(Base + 3))  m_ph   <= bus0.set_data[17:0];
      if (bus0.set_addr == 8'(Base + 4))  m_swap <= bus0.set_data[0];
    end
  end

  function automatic longint sat24(input longint v, output bit flag);
    flag = 1'b0;
    if (v > 64'sd8388607) begin
      flag = 1'b1;
      return 64'sd8388607;
    end
    if (v < -64'sd8388608) begin
      flag = 1'b1;
      return -64'sd8388608;
    end
    return v;
  endfunction

  function automatic longint round_out(input longint v, output bit flag);
    longint r;
    flag = 1'b0;
    if (W == 24) return v;
    r = (v + (64'sd1 <<< (23 - W))) >>> (24 - W);
    if (r > (64'sd1 <<< (W - 1)) - 1) begin
      flag = 1'b1;
      r = (64'sd1 <<< (W - 1)) - 1;
    end
    return r;
  endfunction

  // Output after edge t: sample entered at t-3, products use settings at t-2,
  // DC at t-1, swap at t; any reset inside that span wipes what it reached.
  function automatic void model(input int t, input bit iq, output longint ea,
                                output longint eb, output bit ec);
    longint di, dq, pi, pq, si, sq, oi, oq;
    bit s3i, s3q, r4i, r4q;
    ea = 0;
    eb = 0;
    ec = 1'b0;
    if (rst_h[t]) return;
    si = 0;
    sq = 0;
    s3i = 1'b0;
    s3q = 1'b0;
    if (!rst_h[t-1]) begin
      di = (rst_h[t-3] || rst_h[t-2] || !run_h[t-3]) ? 0 : longint'(i_h[t-3]);
      dq = (rst_h[t-3] || rst_h[t-2] || !run_h[t-3]) ? 0 : longint'(q_h[t-3]);
      pi = 0;
      pq = 0;
      if (iq) begin
        pi = ((di >>> 6) * longint'(mag_h[t-2])) >>> 12;
        pq = ((di >>> 6) * longint'(ph_h[t-2])) >>> 12;
      end
      si = sat24(di + pi + longint'(dci_h[t-1]), s3i);
      sq = sat24(dq + pq + longint'(dcq_h[t-1]), s3q);
    end
    oi = round_out(si, r4i);
    oq = round_out(sq, r4q);
    ea = swap_h[t] ? oq : oi;
    eb = swap_h[t] ? oi : oq;
    ec = s3i | s3q | r4i | r4q;
  endfunction

  always @(negedge clk) begin
    int t;
    longint ea, eb;
    bit ec;
    t = edge_n - 1;
    if (t >= 3 && t < N) begin
      model(t, 1'b1, ea, eb, ec);
      check("model dut0 dac_a", bus0.dac_a, W'(ea));
      check("model dut0 dac_b", bus0.dac_b, W'(eb));
      check("model dut0 clip", W'(bus0.clip), W'(ec));
      model(t, 1'b0, ea, eb, ec);
      check("model dut1 dac_a", bus1.dac_a, W'(ea));
      check("model dut1 dac_b", bus1.dac_b, W'(eb));
      check("model dut1 clip", W'(bus1.clip), W'(ec));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    bus0.set_stb  = 1'b1;
    bus0.set_addr = 8'(a);
    bus0.set_data = d;
    @(negedge clk);
    bus0.set_stb  = 1'b0;
  endtask

  task automatic lit(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                     input bit ec);
    check({name, " dac_a"}, bus0.dac_a, ea);
    check({name, " dac_b"}, bus0.dac_b, eb);
    check({name, " clip"}, W'(bus0.clip), W'(ec));
  endtask

  task automatic lit1(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb);
    check({name, " dut1 dac_a"}, bus1.dac_a, ea);
    check({name, " dut1 dac_b"}, bus1.dac_b, eb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus0.set_stb  = 1'b0;
    bus0.set_addr = '0;
    bus0.set_data = '0;
    bus0.i_in     = '0;
    bus0.q_in     = '0;
    bus0.run      = 1'b0;
    step(4);

    // Defaults pass through; zeros during fill
    rst       = 1'b0;
    bus0.i_in = 24'h123400;
    bus0.q_in = 24'h567800;
    bus0.run  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      lit("fill", 16'h0000, 16'h0000, 1'b0);
    end
    step(1);
    lit("passthru", 16'h1234, 16'h5678, 1'b0);

    // DC offsets and ignored addresses
    wr(Base, 32'h0000_0100);
    wr(Base + 1, 32'h00FF_FF00);
    step(5);
    lit("dc", 16'h1235, 16'h5677, 1'b0);
    wr(Base + 5, 32'h00FF_FFFF);
    wr(Base - 1, 32'h00FF_FFFF);
    step(5);
    lit("ignored addr", 16'h1235, 16'h5677, 1'b0);

    // Saturation in S3 and on rounding
    wr(Base, 32'h0000_1000);
    bus0.i_in = 24'h7FFF00;
    step(5);
    lit("sat pos", 16'h7FFF, 16'h5677, 1'b1);
    wr(Base, 32'h00FF_FFFF);
    bus0.i_in = 24'h800000;
    step(5);
    lit("sat neg", 16'h8000, 16'h5677, 1'b1);
    bus0.i_in = 24'h7FFF90;
    step(5);
    lit("round ovf", 16'h7FFF, 16'h5677, 1'b1);
    bus0.i_in = 24'h7FFF7F;
    step(5);
    lit("round edge", 16'h7FFF, 16'h5677, 1'b0);
    bus0.i_in = 24'h123400;
    step(5);
    lit("in range", 16'h1234, 16'h5677, 1'b0);

    // IQ correction
    wr(Base, 32'h0);
    wr(Base + 1, 32'h0);
    wr(Base + 2, 32'h0000_1000);
    wr(Base + 3, 32'h0000_1000);
    bus0.i_in = 24'h100000;
    bus0.q_in = 24'h000000;
    step(5);
    lit("iqcomp", 16'h1040, 16'h0040, 1'b0);
    lit1("iqcomp off", 16'h1000, 16'h0000);
    bus0.i_in = 24'hF00000;
    step(5);
    lit("iqcomp neg", 16'hEFC0, 16'hFFC0, 1'b0);
    lit1("iqcomp neg off", 16'hF000, 16'h0000);
    wr(Base + 2, 32'h0);
    wr(Base + 3, 32'h0);

    // Swap lands on an exact sample boundary
    bus0.i_in = 24'h123400;
    bus0.q_in = 24'h567800;
    step(5);
    lit("preswap", 16'h1234, 16'h5678, 1'b0);
    wr(Base + 4, 32'h1);
    lit("swap edge", 16'h1234, 16'h5678, 1'b0);
    step(1);
    lit("swapped", 16'h5678, 16'h1234, 1'b0);

    // Mixed traffic, settings writes and one reset, checked by the model
    for (int k = 0; k < 240; k++) begin
      bus0.i_in = 24'($urandom);
      bus0.q_in = 24'($urandom);
      bus0.run  = ($urandom_range(0, 7) != 0);
      rst       = (k == 120);
      if ($urandom_range(0, 3) == 0) begin
        bus0.set_stb  = 1'b1;
        bus0.set_addr = 8'(Base - 1 + $urandom_range(0, 6));
        bus0.set_data = $urandom;
      end else begin
        bus0.set_stb = 1'b0;
      end
      step(1);
    end
    rst          = 1'b0;
    bus0.set_stb = 1'b0;

    // Idle at calibrated DC, then reset clears settings (and beats a write)
    wr(Base + 4, 32'h0);
    wr(Base + 1, 32'h0);
    wr(Base + 2, 32'h0);
    wr(Base + 3, 32'h0);
    wr(Base, 32'h0000_1200);
    bus0.run = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus0.i_in = 24'($urandom);
      bus0.q_in = 24'($urandom);
      step(1);
      if (k >= 4) lit("idle dc", 16'h0012, 16'h0000, 1'b0);
    end
    rst           = 1'b1;
    bus0.set_stb  = 1'b1;
    bus0.set_addr = 8'(Base);
    bus0.set_data = 32'h0000_5000;
    step(1);
    rst          = 1'b0;
    bus0.set_stb = 1'b0;
    lit("after rst", 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      lit("post rst", 16'h0000, 16'h0000, 1'b0);
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
